vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DIV, 4: clk cycles per pixel; legal 1..16.
- CW, 10: width of h_count, v_count, x and y.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- H_ACTIVE, 640: horizontal visible width, in pixels.
- H_FRONT, 16: horizontal front porch, in pixels.
- V_SYNC, 2: vertical sync width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- V_ACTIVE, 480: vertical visible height, in lines.
- V_FRONT, 10: vertical front porch, in lines.
- H_POL, 0: hSync asserted level (0 = active-low).
- V_POL, 0: vSync asserted level (0 = active-low).
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk in 1: the single clock.
- rst_n in 1: synchronous, active-low reset.
- en in 1: run enable; when low, all state holds.
- pix_en out 1: one-clk pixel strobe.
- hSync out 1: horizontal sync.
- vSync out 1: vertical sync.
- bright out 1: pixel is inside the visible area.
- hCount out CW: horizontal position, 0..H_TOTAL-1.
- vCount out CW: vertical position, 0..V_TOTAL-1.
- x out CW: visible-area column.
- y out CW: visible-area row.
- line_start out 1: one-clk pulse when hCount wraps.
- frame_start out 1: one-clk pulse when both counters wrap.
REQ-003 H_TOTAL SHALL equal H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL is formed the same way; H_START = H_SYNC+H_BACK and V_START = V_SYNC+V_BACK.
REQ-004 If H_TOTAL or V_TOTAL exceeds 2^CW, or DIV is outside 1..16, elaboration SHALL fail.

Function
REQ-005 The divider counter SHALL count 0..DIV-1 on each clk with en=1; pix_en is registered and is 1 for exactly one clk, on the cycle after the divider reaches DIV-1.
REQ-006 With DIV=1, pix_en SHALL be 1 on every clk while en=1.
REQ-007 hCount SHALL increment on each pix_en and wrap from H_TOTAL-1 to 0; on that wrap, vCount increments, or wraps from V_TOTAL-1 to 0.
REQ-008 The registered outputs SHALL be aligned: hSync, vSync, bright, x, y, line_start and frame_start always describe the current registered hCount/vCount, with zero skew.
REQ-009 hSync SHALL equal H_POL when hCount < H_SYNC, and ~H_POL otherwise.
REQ-010 vSync SHALL equal V_POL when vCount < V_SYNC, and ~V_POL otherwise.
REQ-011 bright SHALL be 1 exactly when H_START <= hCount < H_START+H_ACTIVE and V_START <= vCount < V_START+V_ACTIVE.
REQ-012 x SHALL equal hCount-H_START and y SHALL equal vCount-V_START when bright=1; both are 0 otherwise.
REQ-013 line_start SHALL be 1 for the single clk in which hCount has just become 0 by wrapping.
REQ-014 frame_start SHALL be 1 for the single clk in which both counters have just become 0; line_start is also 1 in that clk.
REQ-015 While en=0, the divider, counters and all outputs SHALL hold, and pix_en, line_start and frame_start are 0.
REQ-016 When en returns to 1, counting SHALL resume from the held divider value, with no lost or extra pixel.
REQ-017 All counter arithmetic SHALL be unsigned at CW bits; no intermediate result is allowed to overflow.

Reset
REQ-018 On a clk edge with rst_n=0, the block SHALL set: divider=0, hCount=0, vCount=0, pix_en=0, line_start=0, frame_start=0, bright=0, x=0, y=0, hSync=H_POL, vSync=V_POL.
REQ-019 rst_n=0 SHALL override en and take effect mid-line or mid-frame, with no pulse emitted.
REQ-020 After reset, the first clk with rst_n=1 and en=1 SHALL be divider count 0.

Structure
REQ-021 A shared package vga_pkg SHALL hold the default 640x480@60 timing constants and the DIV default.
REQ-022 The divider SHALL be the sub-module pix_clk_en, with parameter DIV and ports clk, rst_n, en, pix_en.
REQ-023 The counters and decode SHALL stay in vga_timing_gen; there are no derived clocks and every flop runs on clk.

Verification
REQ-024 Defaults, release rst_n with en=1 -> pix_en pulses at clk 4, 8, 12, ...; hCount goes 799->0 with line_start=1 after 3200 clk.
REQ-025 Defaults, full frame -> hSync=0 for hCount 0..95; vSync=0 for vCount 0..1; bright first at (144,35) with x=0,y=0 and last at (783,514) with x=639,y=479; frame_start period 1,680,000 clk.
REQ-026 Defaults, rst_n=0 for one clk at hCount=400, vCount=300 -> next clk: hCount=0, vCount=0, hSync=0, bright=0, no frame_start.
REQ-027 Defaults, en=0 for 37 clk mid-line -> all outputs frozen; after en=1, the hCount sequence continues without a gap, and the line period measured in enabled clk stays 3200.
REQ-028 DIV=1 with H 2/1/4/1 and V 1/1/3/1, H_POL=1, V_POL=1 -> H_TOTAL=8, V_TOTAL=6; hSync=1 at hCount 0..1; frame_start every 48 clk; bright for 12 clk per frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants for the VGA generator: 640x480@60 defaults and the
// default pixel-clock divide ratio.
package vga_pkg;

  localparam int unsigned DefDiv     = 4;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBack   = 48;
  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFront  = 16;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBack   = 33;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFront  = 10;

  // Length of one full scan direction (sync + back porch + active + front porch).
  function automatic int unsigned span_total(input int unsigned sync_w, input int unsigned back_w,
                                             input int unsigned act_w, input int unsigned front_w);
    return sync_w + back_w + act_w + front_w;
  endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel-rate strobe generator: one registered pix_en pulse every DIV enabled clocks.
module pix_clk_en
  import vga_pkg::*;
#(
  parameter int unsigned DIV = DefDiv
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pix_en
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV == 0 || DIV > 16) begin : g_div_chk
    $fatal(1, "pix_clk_en: DIV must be in 1..16");
  end

  logic [DW-1:0] div_q, div_d;
  logic          pix_q, pix_d;

  // With en low everything freezes, including a pending strobe, so the parent
  // consumes it on the next enabled edge without losing a pixel.
  always_comb begin
    div_d = div_q;
    pix_d = pix_q;
    if (en) begin
      pix_d = (div_q == DW'(DIV - 1));
      div_d = pix_d ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      pix_q <= 1'b0;
    end else begin
      div_q <= div_d;
      pix_q <= pix_d;
    end
  end

  assign pix_en = pix_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal/vertical counters advanced by the pixel strobe,
// with sync, visible-area and position outputs registered alongside the counters.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned DIV      = DefDiv,
  parameter int unsigned CW       = 10,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BACK   = DefHBack,
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FRONT  = DefHFront,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BACK   = DefVBack,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FRONT  = DefVFront,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          pix_en,
  output logic          hSync,
  output logic          vSync,
  output logic          bright,
  output logic [CW-1:0] hCount,
  output logic [CW-1:0] vCount,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned HTotal = span_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int unsigned VTotal = span_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
  localparam int unsigned HStart = H_SYNC + H_BACK;
  localparam int unsigned VStart = V_SYNC + V_BACK;

  localparam logic [CW-1:0] HLast     = CW'(HTotal - 1);
  localparam logic [CW-1:0] VLast     = CW'(VTotal - 1);
  localparam logic [CW-1:0] HSyncEnd  = CW'(H_SYNC);
  localparam logic [CW-1:0] VSyncEnd  = CW'(V_SYNC);
  localparam logic [CW-1:0] HActFirst = CW'(HStart);
  localparam logic [CW-1:0] VActFirst = CW'(VStart);
  localparam logic [CW-1:0] HActLast  = CW'(HStart + H_ACTIVE - 1);
  localparam logic [CW-1:0] VActLast  = CW'(VStart + V_ACTIVE - 1);

  if (64'(HTotal) > (64'd1 << CW) || 64'(VTotal) > (64'd1 << CW)) begin : g_size_chk
    $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end

  logic          pix_w;
  logic [CW-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
  logic          hs_q, hs_d, vs_q, vs_d, br_q, br_d;
  logic          line_q, line_d, frame_q, frame_d;

  pix_clk_en #(
    .DIV(DIV)
  ) u_pix_clk_en (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .pix_en(pix_w)
  );

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    line_d  = line_q;
    frame_d = frame_q;
    if (en) begin
      line_d  = 1'b0;
      frame_d = 1'b0;
      if (pix_w) begin
        if (h_q == HLast) begin
          h_d    = '0;
          line_d = 1'b1;
          if (v_q == VLast) begin
            v_d     = '0;
            frame_d = 1'b1;
          end else begin
            v_d = v_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
    end
    // Decode from the next counter values so every output lands with its counter.
    hs_d = (h_d < HSyncEnd) ? H_POL : ~H_POL;
    vs_d = (v_d < VSyncEnd) ? V_POL : ~V_POL;
    br_d = (h_d >= HActFirst) && (h_d <= HActLast) && (v_d >= VActFirst) && (v_d <= VActLast);
    x_d  = br_d ? h_d - HActFirst : '0;
    y_d  = br_d ? v_d - VActFirst : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= H_POL;
      vs_q    <= V_POL;
      br_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      br_q    <= br_d;
      x_q     <= x_d;
      y_q     <= y_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  // Strobes are held across a pause and masked while en is low.
  assign pix_en      = pix_w & en;
  assign line_start  = line_q & en;
  assign frame_start = frame_q & en;
  assign hSync       = hs_q;
  assign vSync       = vs_q;
  assign bright      = br_q;
  assign hCount      = h_q;
  assign vCount      = v_q;
  assign x           = x_q;
  assign y           = y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three parameterisations share clk/rst_n/en and are
// checked every cycle against an arithmetic raster model driven by the enabled-clock count.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic en    = 1'b0;

  logic       pix[3], hs[3], vs[3], br[3], ls[3], fs[3];
  logic [9:0] hc[3], vc[3], xo[3], yo[3];

  // Per-DUT timing table, indexed by DUT number.
  int dv[3]  = '{4, 1, 3};
  int hsw[3] = '{96, 2, 3};
  int hbk[3] = '{48, 1, 2};
  int hac[3] = '{640, 4, 5};
  int hfp[3] = '{16, 1, 2};
  int vsw[3] = '{2, 1, 2};
  int vbk[3] = '{33, 1, 1};
  int vac[3] = '{480, 3, 4};
  int vfp[3] = '{10, 1, 2};
  bit hpl[3] = '{1'b0, 1'b1, 1'b0};
  bit vpl[3] = '{1'b0, 1'b1, 1'b1};
  // Enabled clocks between period events (d0: line_start, d1/d2: frame_start) and
  // enabled clocks with bright=1 per frame.
  int per_want[3] = '{3200, 48, 324};
  int brc_want[3] = '{0, 12, 60};

  vga_timing_gen u_d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_en(pix[0]), .hSync(hs[0]), .vSync(vs[0]),
    .bright(br[0]), .hCount(hc[0]), .vCount(vc[0]), .x(xo[0]), .y(yo[0]),
    .line_start(ls[0]), .frame_start(fs[0])
  );

  vga_timing_gen #(
    .DIV(1), .CW(10), .H_SYNC(2), .H_BACK(1), .H_ACTIVE(4), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1), .H_POL(1'b1), .V_POL(1'b1)
  ) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_en(pix[1]), .hSync(hs[1]), .vSync(vs[1]),
    .bright(br[1]), .hCount(hc[1]), .vCount(vc[1]), .x(xo[1]), .y(yo[1]),
    .line_start(ls[1]), .frame_start(fs[1])
  );

  vga_timing_gen #(
    .DIV(3), .CW(10), .H_SYNC(3), .H_BACK(2), .H_ACTIVE(5), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(2), .H_POL(1'b0), .V_POL(1'b1)
  ) u_d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_en(pix[2]), .hSync(hs[2]), .vSync(vs[2]),
    .bright(br[2]), .hCount(hc[2]), .vCount(vc[2]), .x(xo[2]), .y(yo[2]),
    .line_start(ls[2]), .frame_start(fs[2])
  );

  typedef struct packed {
    logic [2:0][45:0] v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ecount = 0;  // enabled clock edges since the last reset

  // Raster model: pixel strobes every dv enabled clocks; the raster position is the
  // number of strobes already consumed.
  function automatic logic [45:0] model(input int i, input int ec, input bit e);
    int ht, vt, hst, vst, p, h, v, x, y;
    bit pe, adv, l, f, hsy, vsy, b;
    ht  = hsw[i] + hbk[i] + hac[i] + hfp[i];
    vt  = vsw[i] + vbk[i] + vac[i] + vfp[i];
    hst = hsw[i] + hbk[i];
    vst = vsw[i] + vbk[i];
    p   = (ec >= 1) ? (ec - 1) / dv[i] : 0;
    h   = p % ht;
    v   = (p / ht) % vt;
    pe  = e && (ec > 0) && (ec % dv[i] == 0);
    adv = (ec >= 2) && ((ec - 1) % dv[i] == 0);
    l   = e && adv && (h == 0);
    f   = l && (v == 0);
    hsy = (h < hsw[i]) ? hpl[i] : !hpl[i];
    vsy = (v < vsw[i]) ? vpl[i] : !vpl[i];
    b   = (h >= hst) && (h < hst + hac[i]) && (v >= vst) && (v < vst + vac[i]);
    x   = b ? h - hst : 0;
    y   = b ? v - vst : 0;
    return {pe, hsy, vsy, b, l, f, 10'(h), 10'(v), 10'(x), 10'(y)};
  endfunction

  task automatic step(input bit r, input bit e);
    exp_t ex;
    @(negedge clk);
    rst_n = r;
    en    = e;
    if (!r) ecount = 0;
    else if (e) ecount++;
    for (int i = 0; i < 3; i++) ex.v[i] = model(i, ecount, e);
    q.push_back(ex);
  endtask

  // Monitor: compares every post-edge sample against the queued expectation and
  // measures event periods in enabled clocks.
  initial begin : monitor
    exp_t        ex;
    logic [45:0] act;
    int          cnt[3];
    int          brc[3];
    bit          have[3];
    bit          evt;
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0; brc[i] = 0; have[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        ex = q.pop_front();
        for (int i = 0; i < 3; i++) begin
          act = {pix[i], hs[i], vs[i], br[i], ls[i], fs[i], hc[i], vc[i], xo[i], yo[i]};
          total++;
          if (act !== ex.v[i]) begin
            bad++;
            $display("FAIL dut%0d outputs {pix,hs,vs,br,ls,fs,h,v,x,y} got=%h want=%h",
                     i, act, ex.v[i]);
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          have[i] = 1'b0; cnt[i] = 0; brc[i] = 0;
        end else if (en) begin
          cnt[i]++;
          if (br[i] === 1'b1) brc[i]++;
          evt = (i == 0) ? (ls[0] === 1'b1) : (fs[i] === 1'b1);
          if (evt) begin
            if (have[i]) begin
              total++;
              if (cnt[i] != per_want[i]) begin
                bad++;
                $display("FAIL dut%0d period got=%0d want=%0d", i, cnt[i], per_want[i]);
              end
              if (i > 0) begin
                total++;
                if (brc[i] != brc_want[i]) begin
                  bad++;
                  $display("FAIL dut%0d bright_per_frame got=%0d want=%0d", i, brc[i],
                           brc_want[i]);
                end
              end
            end
            have[i] = 1'b1; cnt[i] = 0; brc[i] = 0;
          end
        end
      end
    end
  end

  initial begin : driver
    bit reached;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    // Free run from reset, then a 37-clock pause mid-line.
    for (int k = 0; k < 4000; k++) step(1'b1, 1'b1);
    for (int k = 0; k < 37; k++) step(1'b1, 1'b0);
    for (int k = 0; k < 2500; k++) step(1'b1, 1'b1);
    // Advance the default raster to hCount=400, then reset for one clock.
    reached = 1'b0;
    for (int k = 0; k < 4000 && !reached; k++) begin
      step(1'b1, 1'b1);
      if ((((ecount - 1) / 4) % 800 == 400) && ((ecount - 1) % 4 == 0)) reached = 1'b1;
    end
    total++;
    if (!reached) begin
      bad++;
      $display("FAIL reach_h400 got=0 want=1");
    end
    step(1'b0, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1);
    // Random enable with rare resets.
    for (int k = 0; k < 40000; k++)
      step(($urandom_range(0, 999) != 0), ($urandom_range(0, 3) != 0));
    for (int k = 0; k < 400; k++) step(1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
